// File: rtl/cmd_ram_sequencer_if.sv
// Command RAM sequencer bundle: send_control request, RAM read port and Avalon-ST source.
// Latency: n/a (wiring only).
// Backpressure: st_ready from the sink; master = sequencer side, slave = environment side.
interface cmd_ram_sequencer_if;
    logic [5:0]  start_ram_addr;
    logic        send_cmd;
    logic        ram_rd_en;
    logic [5:0]  ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_sop;
    logic        st_eop;
    logic        busy;
    logic        done;
    logic        truncated;
    logic        cmd_dropped;

    modport master (
        input  start_ram_addr, send_cmd, ram_rd_data, st_ready,
        output ram_rd_en, ram_rd_addr, st_data, st_valid, st_sop, st_eop,
        output busy, done, truncated, cmd_dropped
    );

    modport slave (
        output start_ram_addr, send_cmd, ram_rd_data, st_ready,
        input  ram_rd_en, ram_rd_addr, st_data, st_valid, st_sop, st_eop,
        input  busy, done, truncated, cmd_dropped
    );
endinterface

// File: rtl/cmd_ram_sequencer.sv
// Streams one command (up to MAX_WORDS RAM words, ends on LAST_BIT or the count) onto Avalon-ST.
// Latency: send_cmd at T -> first RAM read at T+1 -> first st_valid at T+3; then 1 word/cycle.
// Backpressure: st_ready stalls the 2-entry output FIFO; reads are issued only when a slot is guaranteed.
// Ports: clk/rst_n plain; bus carries send_control, RAM read port, stream source and status pulses.
module cmd_ram_sequencer #(
    parameter int MAX_WORDS = 16,
    parameter int LAST_BIT  = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    cmd_ram_sequencer_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [6:0] MAX_CNT = 7'(MAX_WORDS);

    logic [1:0]  state;
    logic [5:0]  rd_ptr;
    logic        rd_pend;      // a read was issued last cycle; its data is on ram_rd_data now
    logic [6:0]  word_cnt;
    logic        sop_pend;
    logic        trunc_q;
    logic        dropped_q;

    logic [31:0] fifo_dat [2];
    logic [1:0]  fifo_sop;
    logic [1:0]  fifo_eop;
    logic        fifo_wr_idx;
    logic        fifo_rd_idx;
    logic [1:0]  fifo_cnt;

    logic        accept;
    logic        pop;
    logic        push;
    logic        issue;
    logic        hit_last;
    logic        hit_max;
    logic        push_eop;
    logic        st_valid;
    logic        st_eop;
    logic        busy;
    logic [2:0]  occupancy;
    logic [2:0]  limit;
    logic [6:0]  word_cnt_nxt;

    always_comb begin
        // The DONE cycle counts as idle for acceptance: busy is already low there.
        accept       = bus.send_cmd && (state == IDLE || state == DONE);
        busy         = (state == FETCH) || (state == DRAIN);
        st_valid     = (fifo_cnt != 2'd0);
        st_eop       = st_valid && fifo_eop[fifo_rd_idx];
        pop          = st_valid && bus.st_ready;
        push         = (state == FETCH) && rd_pend;
        word_cnt_nxt = word_cnt + 7'd1;
        hit_last     = bus.ram_rd_data[LAST_BIT];
        hit_max      = (word_cnt_nxt == MAX_CNT);
        push_eop     = hit_last || hit_max;
        // FIFO words plus the read in flight must fit in two slots; a pop this
        // cycle frees one, which is what sustains one word per cycle.
        occupancy    = {1'b0, fifo_cnt} + {2'b00, rd_pend};
        limit        = pop ? 3'd3 : 3'd2;
        issue        = (state == FETCH) && (occupancy < limit);
    end

    assign bus.ram_rd_en   = issue;
    assign bus.ram_rd_addr = rd_ptr;
    assign bus.st_valid    = st_valid;
    assign bus.st_data     = fifo_dat[fifo_rd_idx];
    assign bus.st_sop      = st_valid && fifo_sop[fifo_rd_idx];
    assign bus.st_eop      = st_eop;
    assign bus.busy        = busy;
    assign bus.done        = (state == DONE);
    assign bus.truncated   = (state == DONE) && trunc_q;
    assign bus.cmd_dropped = dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            rd_pend   <= 1'b0;
            word_cnt  <= '0;
            sop_pend  <= 1'b0;
            trunc_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            rd_pend   <= issue;
            dropped_q <= bus.send_cmd && busy;
            if (issue) begin
                rd_ptr <= rd_ptr + 6'd1;   // natural 6-bit wrap 63 -> 0
            end
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state    <= FETCH;
                        rd_ptr   <= bus.start_ram_addr;
                        word_cnt <= '0;
                        sop_pend <= 1'b1;
                        trunc_q  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    if (push) begin
                        word_cnt <= word_cnt_nxt;
                        sop_pend <= 1'b0;
                        if (push_eop) begin
                            // Leaving FETCH stops issue; a read still in flight
                            // returns during DRAIN and is simply not pushed.
                            state   <= DRAIN;
                            trunc_q <= hit_max && !hit_last;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && st_eop) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_dat[0] <= '0;
            fifo_dat[1] <= '0;
            fifo_sop    <= '0;
            fifo_eop    <= '0;
            fifo_wr_idx <= 1'b0;
            fifo_rd_idx <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (push) begin
                fifo_dat[fifo_wr_idx] <= bus.ram_rd_data;
                fifo_sop[fifo_wr_idx] <= sop_pend;
                fifo_eop[fifo_wr_idx] <= push_eop;
                fifo_wr_idx           <= ~fifo_wr_idx;
            end
            if (pop) begin
                fifo_rd_idx <= ~fifo_rd_idx;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
